// File: rtl/score_bcd_formatter.sv
// Binary score to BCD digits via iterative double-dabble, with a frame-synchronous
// double buffer so the displayed digits and blank mask only change on frame_in.
module score_bcd_formatter #(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  input  logic [SCORE_W-1:0]      score_in,
  input  logic                    start_in,
  input  logic                    frame_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]           MAX_VAL   = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(SCORE_W - 1);
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);

  // Clamp before conversion so the BCD accumulator never needs an extra digit.
  function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] s);
    if (64'(s) > MAX_VAL) return SCORE_W'(MAX_VAL);
    return s;
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd);
    logic [NUM_DIGITS-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (bcd[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [SCORE_W-1:0]       bin_sr;
  logic [BCD_W-1:0]         bcd_sr;
  logic [BCD_W+SCORE_W-1:0] shift_cat;
  logic [BCD_W-1:0]         pend_digits;
  logic [NUM_DIGITS-1:0]    pend_blank;
  logic                     pend_vld;

  assign shift_cat = {add3(bcd_sr), bin_sr} << 1;
  assign busy_out  = (state != IDLE);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (start_in) begin
        state_n = SHIFT;
        cnt_n   = '0;
      end
      SHIFT: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == LAST_CNT) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Conversion datapath; an aborted conversion is simply reloaded on the next start.
  always_ff @(posedge pixel_clk_in) begin
    if (state == IDLE && start_in) begin
      bin_sr <= saturate(score_in);
      bcd_sr <= '0;
    end else if (state == SHIFT) begin
      {bcd_sr, bin_sr} <= shift_cat;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (state == DONE) begin
      pend_digits <= bcd_sr;
      pend_blank  <= blank_mask(bcd_sr);
    end
  end

  // A result completing on a frame edge goes straight to the display.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      done_out   <= 1'b0;
      pend_vld   <= 1'b0;
      digits_out <= '0;
      blank_out  <= BLANK_RST;
    end else begin
      done_out <= (state == DONE);
      if (state == DONE) begin
        if (frame_in) begin
          digits_out <= bcd_sr;
          blank_out  <= blank_mask(bcd_sr);
          pend_vld   <= 1'b0;
        end else begin
          pend_vld <= 1'b1;
        end
      end else if (frame_in && pend_vld) begin
        digits_out <= pend_digits;
        blank_out  <= pend_blank;
        pend_vld   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_formatter.sv
// Randomised and directed bench for score_bcd_formatter against a decimal-arithmetic model.
module tb_score_bcd_formatter;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in       = 1'b1;
  logic [13:0] score_in     = '0;
  logic        start_in     = 1'b0;
  logic        frame_in     = 1'b0;
  logic        busy_out;
  logic        done_out;
  logic [15:0] digits_out;
  logic [3:0]  blank_out;

  score_bcd_formatter #(.SCORE_W(14), .NUM_DIGITS(4)) dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .score_in     (score_in),
    .start_in     (start_in),
    .frame_in     (frame_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .digits_out   (digits_out),
    .blank_out    (blank_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] m_disp;
  logic [3:0]  m_disp_blank;
  logic [15:0] m_pend;
  logic [3:0]  m_pend_blank;
  bit          m_pv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_dig(input int s);
    int v;
    logic [15:0] r;
    v = (s > 9999) ? 9999 : s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] m_blk(input logic [15:0] d);
    logic [3:0] b;
    b = 4'b0000;
    for (int i = 1; i < 4; i++) b[i] = ((d >> (4 * i)) == 16'd0);
    return b;
  endfunction

  task automatic check_display(input string tag);
    chk({tag, "_digits"}, digits_out, m_disp);
    chk({tag, "_blank"}, blank_out, m_disp_blank);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic convert(input int s, input bit hold, input bit frame_at_done);
    int c;
    int busy_cnt;
    logic [15:0] nd;
    busy_cnt = 0;
    score_in = 14'(s);
    start_in = 1'b1;
    for (c = 1; c <= 40; c++) begin
      @(negedge pixel_clk_in);
      if (!hold) start_in = 1'b0;
      if (busy_out) busy_cnt++;
      if (done_out) break;
      frame_in = frame_at_done && (c == 15);
    end
    start_in = 1'b0;
    frame_in = 1'b0;
    chk("done_latency", c, 16);
    chk("busy_cycles", busy_cnt, 15);
    nd = m_dig(s);
    if (frame_at_done) begin
      m_disp       = nd;
      m_disp_blank = m_blk(nd);
      m_pv         = 1'b0;
    end else begin
      m_pend       = nd;
      m_pend_blank = m_blk(nd);
      m_pv         = 1'b1;
    end
    check_display("after_conv");
    @(negedge pixel_clk_in);
    chk("done_pulse_width", done_out, 0);
  endtask

  task automatic frame_pulse();
    frame_in = 1'b1;
    @(negedge pixel_clk_in);
    frame_in = 1'b0;
    if (m_pv) begin
      m_disp       = m_pend;
      m_disp_blank = m_pend_blank;
      m_pv         = 1'b0;
    end
    check_display("frame");
  endtask

  initial begin
    bit seen_done;
    m_disp       = 16'h0000;
    m_disp_blank = 4'b1110;
    m_pend       = '0;
    m_pend_blank = '0;
    m_pv         = 1'b0;

    repeat (2) @(negedge pixel_clk_in);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    check_display("rst");
    rst_in = 1'b0;
    @(negedge pixel_clk_in);

    convert(1234, 0, 0);
    frame_pulse();
    chk("basic_digits", digits_out, 16'h1234);
    chk("basic_blank", blank_out, 4'b0000);

    convert(7, 0, 0);     frame_pulse();
    convert(0, 0, 0);     frame_pulse();
    chk("zero_blank", blank_out, 4'b1110);
    convert(12000, 0, 0); frame_pulse();
    chk("sat_digits", digits_out, 16'h9999);

    convert(42, 0, 0);
    frame_pulse();
    chk("tear_free_42", digits_out, 16'h0042);
    chk("tear_free_blank", blank_out, 4'b1100);
    frame_pulse();

    convert(5, 1, 0);
    convert(6, 0, 0);
    frame_pulse();
    chk("overwrite_digits", digits_out, 16'h0006);

    convert(9000, 0, 1);
    chk("bypass_digits", digits_out, 16'h9000);
    frame_pulse();

    // Abort a conversion partway through the shift phase.
    score_in = 14'd1234;
    start_in = 1'b1;
    @(negedge pixel_clk_in);
    start_in = 1'b0;
    repeat (4) @(negedge pixel_clk_in);
    #2 rst_in = 1'b1;
    #1;
    m_disp       = 16'h0000;
    m_disp_blank = 4'b1110;
    m_pv         = 1'b0;
    chk("midrst_busy", busy_out, 0);
    check_display("midrst");
    @(negedge pixel_clk_in);
    rst_in    = 1'b0;
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge pixel_clk_in);
      if (done_out) seen_done = 1'b1;
    end
    chk("midrst_no_done", seen_done, 0);
    convert(1234, 0, 0);
    frame_pulse();

    for (int i = 0; i < 25; i++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 9999);
      convert(s, $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) frame_pulse();
    end
    frame_pulse();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
